// File: rtl/cache_ctrl_pkg.sv
// Shared types and address-field positions for the MEM-stage cache controller.
package cache_ctrl_pkg;
   localparam int          ADDR_W    = 19;
   localparam logic [31:0] MEM_BASE  = 32'd1024;
   localparam int          TAG_MSB   = ADDR_W - 1;
   localparam int          INDEX_LSB = 3;
   localparam int          WORD_SEL  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_MEM = 3'd1,
      FILL   = 3'd2,
      WR_SIB = 3'd3,
      WR_MEM = 3'd4
   } state_t;

   // Address of the other 32-bit word in the same 64-bit line.
   function automatic logic [ADDR_W-1:0] sibling(input logic [ADDR_W-1:0] a);
      return {a[TAG_MSB:WORD_SEL+1], ~a[WORD_SEL], a[WORD_SEL-1:0]};
   endfunction
endpackage

// File: rtl/cache_controller_if.sv
// Pipeline, cache and SRAM signal bundle of the cache controller.
interface cache_controller_if;
   import cache_ctrl_pkg::*;

   logic              wr_en, rd_en;
   logic [31:0]       address, wdata, rdata;
   logic              ready;
   logic [ADDR_W-1:0] cache_address;
   logic [31:0]       cache_wdata0, cache_wdata1;
   logic              cache_read, cache_write, cache_update, cache_hit;
   logic [31:0]       cache_rdata;
   logic              sram_rd_en, sram_wr_en;
   logic [ADDR_W-1:0] sram_address;
   logic [31:0]       sram_wdata;
   logic [63:0]       sram_rdata;
   logic              sram_ready;

   modport slave (
      input  wr_en, rd_en, address, wdata, cache_hit, cache_rdata, sram_rdata, sram_ready,
      output rdata, ready, cache_address, cache_wdata0, cache_wdata1, cache_read,
             cache_write, cache_update, sram_rd_en, sram_wr_en, sram_address, sram_wdata
   );

   modport master (
      output wr_en, rd_en, address, wdata, cache_hit, cache_rdata, sram_rdata, sram_ready,
      input  rdata, ready, cache_address, cache_wdata0, cache_wdata1, cache_read,
             cache_write, cache_update, sram_rd_en, sram_wr_en, sram_address, sram_wdata
   );
endinterface

// File: rtl/cache_controller_stats_counter.sv
// Saturating 32-bit event counter for the controller statistics.
module cache_stats_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (inc && count != 32'hFFFF_FFFF)
         count <= count + 32'd1;
   end
endmodule

// File: rtl/cache_controller.sv
// MEM-stage controller: zero-wait read hits, line fill on read miss, write-through no-allocate.
// CACHE_CTRL_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_controller
   import cache_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cache_controller_if.slave  bus
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
`endif
);
   state_t            state, nxt;
   logic [ADDR_W-1:0] addr_q, eff;
   logic [31:0]       wdata_q, sib_word, offs;
   logic              sib_hit;
   logic [63:0]       line_buf;
   logic              is_rd, rd_hit, rd_miss;
   logic              unused;

   assign offs    = bus.address - MEM_BASE;
   assign eff     = {offs[ADDR_W-1:2], 2'b00};
   assign unused  = &{1'b0, offs[31:ADDR_W], offs[1:0]};
   // A simultaneous load/store request is served as a store.
   assign is_rd   = bus.rd_en & ~bus.wr_en;
   assign rd_hit  = (state == IDLE) && is_rd && bus.cache_hit;
   assign rd_miss = (state == IDLE) && is_rd && !bus.cache_hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         sib_word <= '0;
         sib_hit  <= 1'b0;
         line_buf <= '0;
      end else begin
         state <= nxt;
         if (state == IDLE && (bus.wr_en || bus.rd_en)) begin
            addr_q  <= eff;
            wdata_q <= bus.wdata;
         end
         if (state == IDLE && bus.wr_en) begin
            sib_word <= bus.cache_rdata;
            sib_hit  <= bus.cache_hit;
         end
         if (state == RD_MEM && bus.sram_ready)
            line_buf <= bus.sram_rdata;
      end
   end

   always_comb begin
      nxt               = state;
      bus.ready         = 1'b0;
      bus.rdata         = '0;
      bus.cache_address = addr_q;
      bus.cache_wdata0  = '0;
      bus.cache_wdata1  = '0;
      bus.cache_read    = 1'b0;
      bus.cache_write   = 1'b0;
      bus.cache_update  = 1'b0;
      bus.sram_rd_en    = 1'b0;
      bus.sram_wr_en    = 1'b0;
      bus.sram_address  = addr_q;
      bus.sram_wdata    = wdata_q;
      case (state)
         IDLE: begin
            bus.cache_address = eff;
            if (bus.wr_en) begin
               // Probe the sibling word so a write hit can rewrite the whole line.
               bus.cache_address = sibling(eff);
               nxt               = WR_SIB;
            end else if (rd_hit) begin
               bus.cache_read = 1'b1;
               bus.ready      = 1'b1;
               bus.rdata      = bus.cache_rdata;
            end else if (rd_miss) begin
               bus.cache_read = 1'b1;
               nxt            = RD_MEM;
            end else begin
               bus.ready = 1'b1;
            end
         end
         RD_MEM: begin
            bus.sram_rd_en   = 1'b1;
            bus.sram_address = {addr_q[TAG_MSB:INDEX_LSB], 3'b000};
            if (bus.sram_ready) nxt = FILL;
         end
         FILL: begin
            bus.cache_write  = 1'b1;
            bus.cache_wdata0 = line_buf[31:0];
            bus.cache_wdata1 = line_buf[63:32];
            bus.ready        = 1'b1;
            bus.rdata        = addr_q[WORD_SEL] ? line_buf[63:32] : line_buf[31:0];
            nxt              = IDLE;
         end
         WR_SIB: nxt = WR_MEM;
         WR_MEM: begin
            bus.sram_wr_en = 1'b1;
            if (bus.sram_ready) begin
               bus.ready = 1'b1;
               nxt       = IDLE;
               if (sib_hit) begin
                  bus.cache_write  = 1'b1;
                  bus.cache_update = 1'b1;
                  bus.cache_wdata0 = addr_q[WORD_SEL] ? sib_word : wdata_q;
                  bus.cache_wdata1 = addr_q[WORD_SEL] ? wdata_q : sib_word;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

`ifdef CACHE_CTRL_STATS_EN
   cache_stats_counter u_hits (.clk(clk), .rst(rst), .inc(rd_hit),  .count(hit_count));
   cache_stats_counter u_miss (.clk(clk), .rst(rst), .inc(rd_miss), .count(miss_count));
`endif
endmodule
